// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer slice.
//   fib_state_e : sequencing FSM states
//   SEL_*       : encodings of the 2-bit term mux select
package fib_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED0,
      SEED1,
      RUN,
      DONE
   } fib_state_e;

   localparam logic [1:0] SEL_SEED0 = 2'b00;
   localparam logic [1:0] SEL_SEED1 = 2'b01;
   localparam logic [1:0] SEL_SUM   = 2'b10;
   localparam logic [1:0] SEL_HOLD  = 2'b11;

endpackage

// File: rtl/fib_step_dp.sv
// Term datapath: prev/curr registers and the WIDTH+1 bit adder.
// Build option: FIB_SAT_EN saturates curr to all-ones on carry instead of wrapping.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : zero both registers (start of a run)
//   seed_i     : load prev=0, curr=1
//   adv_i      : prev<=curr, curr<=next term
//   curr_o     : current term (drives fib_out)
//   carry_o    : prev+curr does not fit in WIDTH bits
module fib_step_dp #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             seed_i,
   input  logic             adv_i,
   output logic [WIDTH-1:0] curr_o,
   output logic             carry_o
);

   logic [WIDTH-1:0] prev_q, curr_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] next_term;

   always_comb begin
      sum     = {1'b0, prev_q} + {1'b0, curr_q};
      carry_o = sum[WIDTH];
`ifdef FIB_SAT_EN
      next_term = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
      next_term = sum[WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
         curr_q <= '0;
      end else if (clear_i) begin
         prev_q <= '0;
         curr_q <= '0;
      end else if (seed_i) begin
         prev_q <= '0;
         curr_q <= {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (adv_i) begin
         prev_q <= curr_q;
         curr_q <= next_term;
      end
   end

   assign curr_o = curr_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Sequencing FSM for the Fibonacci datapath; one term per enabled step.
// Build option: FIB_SAT_EN (saturating terms, handled in fib_step_dp).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a run (honoured in IDLE/DONE only)
//   step_en    : advance one term (honoured in SEED0/SEED1/RUN only)
//   mux_sel    : term mux select (seed0/seed1/sum/hold)
//   fib_out    : current term
//   term_idx   : index of fib_out within the run
//   valid      : fib_out is a live term
//   overflow   : sticky, a sum carried out during this run
//   done       : run complete, held until next start
// All outputs are registered.
module fib_seq_ctrl
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_TERMS = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step_en,
   output logic [1:0]       mux_sel,
   output logic [WIDTH-1:0] fib_out,
   output logic [WIDTH:0]   term_idx,
   output logic             valid,
   output logic             overflow,
   output logic             done
);

   localparam int unsigned  IdxW    = WIDTH + 1;
   localparam logic [WIDTH:0] LastIdx = IdxW'(MAX_TERMS - 1);

   fib_state_e     state_q, state_d;
   logic [1:0]     sel_q, sel_d;
   logic [WIDTH:0] idx_q, idx_d;
   logic           valid_q, valid_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;
   logic           dp_clear, dp_seed, dp_adv, dp_carry;

   fib_step_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(dp_clear),
      .seed_i (dp_seed),
      .adv_i  (dp_adv),
      .curr_o (fib_out),
      .carry_o(dp_carry)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = SEL_HOLD;
      idx_d    = idx_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      done_d   = done_q;
      dp_clear = 1'b0;
      dp_seed  = 1'b0;
      dp_adv   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            // start wins; a coincident step_en is dropped this cycle
            if (start) begin
               state_d  = SEED0;
               sel_d    = SEL_SEED0;
               idx_d    = '0;
               valid_d  = 1'b1;
               ovf_d    = 1'b0;
               done_d   = 1'b0;
               dp_clear = 1'b1;
            end
         end
         SEED0: begin
            if (step_en) begin
               state_d = SEED1;
               sel_d   = SEL_SEED1;
               idx_d   = IdxW'(1);
               dp_seed = 1'b1;
            end
         end
         SEED1, RUN: begin
            if (step_en) begin
               if (idx_q == LastIdx) begin
                  // terminal step: no new sum, last term stays on display
                  state_d = DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  sel_d   = SEL_SUM;
                  idx_d   = idx_q + IdxW'(1);
                  dp_adv  = 1'b1;
                  if (dp_carry) ovf_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= SEL_HOLD;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign mux_sel  = sel_q;
   assign term_idx = idx_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;
   assign done     = done_q;

endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencing FSM for the 4-bit Fibonacci datapath; produces one Fibonacci term per enabled step.
- Drives the 2-bit select of the shared 4:1 term mux: seed-0, seed-1, sum, hold.
- Owns the prev/curr term registers, term counter, overflow detection and start/done handshake.
- Sits between the board-level control (start/step buttons, debounced upstream) and the display path.

Parameters:
WIDTH, 4, term width in bits
MAX_TERMS, 12, number of terms emitted per run (idx 0..MAX_TERMS-1); legal range 2..2**(WIDTH+1)-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  begin a run; sampled only in IDLE or DONE
step_en  input  1  advance one term; ignored outside SEED0/SEED1/RUN
mux_sel  output  2  term mux select: 00 seed 0, 01 seed 1, 10 sum, 11 hold
fib_out  output  WIDTH  current term (registered)
term_idx  output  WIDTH+1  index of fib_out within the run (registered)
valid  output  1  fib_out holds a live term
overflow  output  1  sticky; sum exceeded WIDTH bits during this run
done  output  1  run complete; held until next start

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, mux_sel=11, fib_out=0, term_idx=0, valid=0, overflow=0, done=0; prev/curr=0. Reset wins over all inputs, including mid-run.
- States: IDLE, SEED0, SEED1, RUN, DONE. All outputs are registers; no combinational input-to-output path.
- IDLE: start=1 -> SEED0. Outputs after that edge: fib_out=0, term_idx=0, valid=1, mux_sel=00, overflow=0, done=0.
- SEED0: step_en=1 -> SEED1; fib_out=1, term_idx=1, mux_sel=01, prev=0, curr=1.
- SEED1/RUN on step_en=1:
  - sum = prev+curr, computed at WIDTH+1 bits.
  - fib_out=sum[WIDTH-1:0], term_idx+1, mux_sel=10; prev<=curr, curr<=sum[WIDTH-1:0]; state=RUN.
  - If sum[WIDTH]=1, overflow<=1 and the run continues on truncated values.
- Terminal step: step_en=1 while term_idx==MAX_TERMS-1 -> DONE. done=1, valid=0, mux_sel=11; fib_out and term_idx hold the last term. No sum is computed on this step.
- step_en=0 in any active state: mux_sel=11; all registers hold.
- DONE: start=1 -> SEED0 with the same outputs as IDLE->SEED0; overflow cleared.
- start while in SEED0/SEED1/RUN: ignored.
- start and step_en high together in IDLE/DONE: start taken, step ignored that cycle.
- MAX_TERMS=2: the terminal step from SEED1 goes straight to DONE.
- Latency: one clock from the qualifying input edge to the output update.

Optional Feature:
- Macro FIB_SAT_EN.
- Defined: when sum[WIDTH]=1, fib_out and curr are forced to all-ones. Overflow is still set. Later terms saturate, because any sum involving all-ones carries.
- Undefined: modulo-2**WIDTH wrap as described in Behaviour.

Decomposition:
- Package fib_pkg:
  - state enum: IDLE, SEED0, SEED1, RUN, DONE.
  - mux-select constants: SEL_SEED0=2'b00, SEL_SEED1=2'b01, SEL_SUM=2'b10, SEL_HOLD=2'b11.
- One sub-module, fib_step_dp:
  - prev/curr registers, WIDTH+1 adder, saturate/wrap select, carry output.
  - Controlled by load/advance strobes from the FSM.

Test Plan:
- Reset then start=1, then 11 step_en pulses (WIDTH=4, MAX_TERMS=12) -> fib_out 0,1,1,2,3,5,8,13,5,2,7,9. Overflow rises with idx 8 (21 mod 16=5). On the 12th step: done=1, valid=0.
- Same run with FIB_SAT_EN -> idx 8..11 read 15; overflow=1 from idx 8.
- step_en gapped (1,0,0,1...) -> outputs hold, mux_sel=11 on every idle cycle; term sequence identical to the first case.
- start pulsed mid-RUN at idx 4 -> ignored, idx 5=5. start in DONE -> fib_out=0, idx=0, overflow=0, done=0.
- rst_n low at idx 6 with step_en=1 -> the next cycle is IDLE with all outputs at reset values; a later start begins at idx 0.
- start and step_en asserted together in IDLE -> SEED0 with idx 0 only; no double advance.
